uart_cmd_frame_engine: RTL and testbench
========================================

Name: uart_cmd_frame_engine

Overview:
- Framed, parametrised successor to the single-byte UART command pipeline.
- Sits between UART_RX (byte stream in) and UART_TX (byte stream out).
- Assembles multi-byte command frames, checks the checksum, and executes an ALU operation at OPERAND_W width.
- Returns a response frame over TX and drives the latest good result to the top level.

Parameters:
- OPERAND_W, 16, operand/result width in bits; multiple of 8, 8..32; NB = OPERAND_W/8 bytes per operand.
- TIMEOUT_CYCLES, 100000, max clk cycles between bytes inside a frame; 0 disables timeout.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- rx_data  input  8  received byte from UART_RX
- rx_valid  input  1  one-cycle strobe, rx_data valid
- tx_busy  input  1  UART_TX busy; must assert within 1 cycle of tx_start
- tx_start  output  1  one-cycle request to send tx_data
- tx_data  output  8  byte to transmit, stable while tx_start high
- result  output  OPERAND_W  last successfully computed result
- result_valid  output  1  one-cycle pulse when result updates
- timeout  output  1  one-cycle pulse, frame aborted by inter-byte timeout
- rx_overrun  output  1  one-cycle pulse, byte dropped during EXEC/RESP

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; result=0; counters cleared. Mid-frame or mid-response reset aborts immediately; tx_start drops with reset.
- Command frame, bytes in order: SOF 0xA5, OP, A (NB bytes, MSB first), B (NB bytes, MSB first), CHK.
  - CHK = XOR of OP and all A and B bytes.
- States: IDLE -> OPC -> OPA -> OPB -> CHK -> EXEC -> RESP -> IDLE.
  - IDLE ignores any byte other than 0xA5.
  - OPA and OPB each consume exactly NB bytes, counted by a byte counter.
- Latency:
  - CHK byte accepted at cycle N.
  - EXEC at N+1: compute and register result and status.
  - At N+2: result_valid pulses (status OK only), and the first response byte is offered.
- Opcodes:
  - 0x00 ADD, 0x01 SUB, 0x02 AND, 0x03 OR, 0x04 XOR.
  - 0x05 SHL by B mod OPERAND_W; 0x06 SHR (logical) by B mod OPERAND_W.
  - 0x07 CMP: result = (A<B unsigned) ? 1 : 0.
  - Results truncated to OPERAND_W.
- Status byte:
  - 0x00 OK.
  - 0x01 bad opcode.
  - 0x02 checksum error.
  - Bit7 set on ADD carry-out or SUB borrow.
- Error handling: on bad opcode or checksum error, result is unchanged, no result_valid pulse, and the response carries result bytes = 0.
- Response frame: 0x5A, STATUS, result (NB bytes, MSB first), RCHK = XOR of STATUS and result bytes.
- TX handshake:
  - In RESP, pulse tx_start only when tx_busy=0 and no tx_start was issued the previous cycle.
  - After each pulse, wait for tx_busy=0 before the next byte.
  - After the last byte, go to IDLE without waiting for tx_busy.
- Timeout:
  - Cycle counter clears on each rx_valid in OPC..CHK.
  - On reaching TIMEOUT_CYCLES: pulse timeout, return to IDLE, send no response.
- Overrun: rx_valid during EXEC or RESP drops the byte and pulses rx_overrun. The dropped byte is never treated as SOF.
- Simultaneous events: a timeout terminal count in the same cycle as rx_valid → the byte wins and the counter clears.

Optional Feature:
- Macro UART_CMD_MUL_EN.
- Defined: opcode 0x08 MUL, result = low OPERAND_W bits of A*B; status bit7 set if the high half is nonzero.
- Undefined: 0x08 returns status 0x01 (bad opcode); no multiplier inferred.

Decomposition:
- Package uart_cmd_pkg holds:
  - SOF/response header constants (0xA5, 0x5A);
  - opcode constants;
  - status codes;
  - FSM state encoding.
- Sub-module uart_cmd_alu: combinational, inputs A, B, OP; outputs result, carry/borrow, bad_op; width OPERAND_W.
- Top-level FSM, shift registers, checksum, timeout and TX sequencing live in uart_cmd_frame_engine.

Test Plan:
All cases use OPERAND_W=16; the TX model asserts busy 1 cycle after start for 10 cycles.
1. ADD: A5 00 12 34 00 01 27 → result=0x1235, result_valid one pulse at N+2, TX bytes 5A 00 12 35 27.
2. SUB borrow: A5 01 00 01 00 02 02 → result=0xFFFF, TX 5A 80 FF FF 80.
3. Errors:
   - Bad checksum A5 00 00 01 00 01 FF → TX 5A 02 00 00 02, result unchanged, no result_valid.
   - Opcode 0x0F with CHK 0F → TX 5A 01 00 00 01.
4. Timeout: TIMEOUT_CYCLES=100, send A5 00 12 then idle 100 cycles → one timeout pulse, no tx_start. A following valid ADD frame is processed correctly.
5. Noise, overrun and reset:
   - Bytes 00 FF 5A before a valid frame are ignored.
   - A byte injected during RESP → rx_overrun pulse, response intact.
   - reset=0 mid-response → tx_start=0 immediately, result=0, engine back in IDLE.
6. With UART_CMD_MUL_EN: A5 08 01 00 01 00 08 → result=0x0000, status 0x80, TX 5A 80 00 00 80. Without the macro: TX 5A 01 00 00 01.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants and FSM encoding for the UART command frame engine.
// Optional feature macro: UART_CMD_MUL_EN (adds opcode 0x08 MUL).
package uart_cmd_pkg;

    // Frame headers
    localparam logic [7:0] SOF_BYTE   = 8'hA5;
    localparam logic [7:0] RSP_HDR    = 8'h5A;

    // Opcodes
    localparam logic [7:0] OP_ADD     = 8'h00;
    localparam logic [7:0] OP_SUB     = 8'h01;
    localparam logic [7:0] OP_AND     = 8'h02;
    localparam logic [7:0] OP_OR      = 8'h03;
    localparam logic [7:0] OP_XOR     = 8'h04;
    localparam logic [7:0] OP_SHL     = 8'h05;
    localparam logic [7:0] OP_SHR     = 8'h06;
    localparam logic [7:0] OP_CMP     = 8'h07;
    localparam logic [7:0] OP_MUL     = 8'h08;

    // Status codes; bit7 flags ADD carry / SUB borrow / MUL overflow
    localparam logic [7:0] STS_OK      = 8'h00;
    localparam logic [7:0] STS_BAD_OP  = 8'h01;
    localparam logic [7:0] STS_CHK_ERR = 8'h02;
    localparam logic [7:0] STS_CARRY   = 8'h80;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPC,
        S_OPA,
        S_OPB,
        S_CHK,
        S_EXEC,
        S_RESP
    } state_t;

endpackage

// File: rtl/uart_cmd_alu.sv
// Combinational ALU for the UART command frame engine, OPERAND_W wide.
// Optional feature macro: UART_CMD_MUL_EN (opcode 0x08 MUL; otherwise bad opcode).
module uart_cmd_alu
    import uart_cmd_pkg::*;
#(
    parameter int OPERAND_W = 16
) (
    input  logic [OPERAND_W-1:0] a,
    input  logic [OPERAND_W-1:0] b,
    input  logic [7:0]           op,
    output logic [OPERAND_W-1:0] res,
    output logic                 carry,
    output logic                 bad_op
);

    localparam int SW = (OPERAND_W > 1) ? $clog2(OPERAND_W) : 1;

    logic [SW-1:0]      shamt;
    logic [OPERAND_W:0] sum;
    logic [OPERAND_W:0] diff;

    // OPERAND_W may be 24, so the shift amount needs a true modulo
    assign shamt = SW'(b % OPERAND_W);
    assign sum   = {1'b0, a} + {1'b0, b};
    assign diff  = {1'b0, a} - {1'b0, b};

`ifdef UART_CMD_MUL_EN
    logic [2*OPERAND_W-1:0] prod;
    assign prod = a * b;
`endif

    // Opcode decode; carry doubles as borrow for SUB and overflow for MUL
    always_comb begin
        res    = '0;
        carry  = 1'b0;
        bad_op = 1'b0;
        case (op)
            OP_ADD: begin res = sum[OPERAND_W-1:0];  carry = sum[OPERAND_W];  end
            OP_SUB: begin res = diff[OPERAND_W-1:0]; carry = diff[OPERAND_W]; end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_SHL: res = a << shamt;
            OP_SHR: res = a >> shamt;
            OP_CMP: res = {{(OPERAND_W-1){1'b0}}, (a < b)};
`ifdef UART_CMD_MUL_EN
            OP_MUL: begin
                res   = prod[OPERAND_W-1:0];
                carry = |prod[2*OPERAND_W-1:OPERAND_W];
            end
`endif
            default: bad_op = 1'b1;
        endcase
    end

endmodule

// File: rtl/uart_cmd_frame_engine.sv
// UART command frame engine: assembles A5-framed commands, verifies the XOR
// checksum, runs the ALU and streams a 5A-framed response to UART_TX.
// Optional feature macro: UART_CMD_MUL_EN (enables MUL in uart_cmd_alu).
module uart_cmd_frame_engine
    import uart_cmd_pkg::*;
#(
    parameter int OPERAND_W      = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    input  logic                 tx_busy,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    output logic [OPERAND_W-1:0] result,
    output logic                 result_valid,
    output logic                 timeout,
    output logic                 rx_overrun
);

    localparam int NB = OPERAND_W / 8;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [3:0] LAST_OPB = 4'(NB - 1);
    localparam logic [3:0] LAST_TX  = 4'(NB + 2);

    state_t               state, state_nx;
    logic [7:0]           op_r, chk_acc, status_r, rchk;
    logic [OPERAND_W-1:0] a_r, b_r, resp_res, alu_res;
    logic                 alu_carry, alu_bad, chk_ok, tx_start_q;
    logic                 in_frame, tmo_term, tmo_hit;
    logic [3:0]           byte_cnt, tx_idx;
    logic [TW-1:0]        tmo_cnt;

    uart_cmd_alu #(.OPERAND_W(OPERAND_W)) u_alu (
        .a      (a_r),
        .b      (b_r),
        .op     (op_r),
        .res    (alu_res),
        .carry  (alu_carry),
        .bad_op (alu_bad)
    );

    assign in_frame = (state == S_OPC) || (state == S_OPA) || (state == S_OPB) || (state == S_CHK);
    assign tmo_term = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TMO_LAST);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next state, TX request and timeout detection; an arriving byte beats the timeout
    always_comb begin
        state_nx = state;
        tx_start = 1'b0;
        tmo_hit  = 1'b0;
        case (state)
            S_IDLE: if (rx_valid && rx_data == SOF_BYTE) state_nx = S_OPC;
            S_OPC:  if (rx_valid) state_nx = S_OPA;
            S_OPA:  if (rx_valid && byte_cnt == LAST_OPB) state_nx = S_OPB;
            S_OPB:  if (rx_valid && byte_cnt == LAST_OPB) state_nx = S_CHK;
            S_CHK:  if (rx_valid) state_nx = S_EXEC;
            S_EXEC: state_nx = S_RESP;
            S_RESP: begin
                // busy lags start by a cycle, so also hold off right after a pulse
                if (!tx_busy && !tx_start_q) begin
                    tx_start = 1'b1;
                    if (tx_idx == LAST_TX) state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        if (in_frame && !rx_valid && tmo_term) begin
            tmo_hit  = 1'b1;
            state_nx = S_IDLE;
        end
    end

    // Response byte mux: header, status, result MSB first, checksum
    always_comb begin
        rchk = status_r;
        for (int i = 0; i < NB; i++) rchk = rchk ^ resp_res[8*i +: 8];
        tx_data = 8'h00;
        if (state == S_RESP) begin
            if (tx_idx == 4'd0)         tx_data = RSP_HDR;
            else if (tx_idx == 4'd1)    tx_data = status_r;
            else if (tx_idx == LAST_TX) tx_data = rchk;
            else begin
                for (int i = 0; i < NB; i++)
                    if (tx_idx == 4'(i + 2)) tx_data = resp_res[8*(NB-1-i) +: 8];
            end
        end
    end

    // Frame capture, checksum, execution, pulses and counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_r         <= '0;
            a_r          <= '0;
            b_r          <= '0;
            chk_acc      <= '0;
            chk_ok       <= 1'b0;
            byte_cnt     <= '0;
            tx_idx       <= '0;
            tmo_cnt      <= '0;
            status_r     <= '0;
            resp_res     <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            rx_overrun   <= 1'b0;
            tx_start_q   <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            timeout      <= tmo_hit;
            rx_overrun   <= rx_valid && (state == S_EXEC || state == S_RESP);
            tx_start_q   <= tx_start;
            tmo_cnt      <= (in_frame && !rx_valid) ? tmo_cnt + 1'b1 : '0;
            case (state)
                S_IDLE: begin
                    byte_cnt <= '0;
                    chk_acc  <= '0;
                end
                S_OPC: if (rx_valid) begin
                    op_r    <= rx_data;
                    chk_acc <= chk_acc ^ rx_data;
                end
                S_OPA: if (rx_valid) begin
                    a_r      <= OPERAND_W'({a_r, rx_data});
                    chk_acc  <= chk_acc ^ rx_data;
                    byte_cnt <= (byte_cnt == LAST_OPB) ? 4'd0 : byte_cnt + 4'd1;
                end
                S_OPB: if (rx_valid) begin
                    b_r      <= OPERAND_W'({b_r, rx_data});
                    chk_acc  <= chk_acc ^ rx_data;
                    byte_cnt <= (byte_cnt == LAST_OPB) ? 4'd0 : byte_cnt + 4'd1;
                end
                S_CHK: if (rx_valid) chk_ok <= (chk_acc == rx_data);
                S_EXEC: begin
                    tx_idx <= '0;
                    // a corrupt frame cannot be trusted, so checksum error outranks bad opcode
                    if (!chk_ok) begin
                        status_r <= STS_CHK_ERR;
                        resp_res <= '0;
                    end else if (alu_bad) begin
                        status_r <= STS_BAD_OP;
                        resp_res <= '0;
                    end else begin
                        status_r     <= alu_carry ? STS_CARRY : STS_OK;
                        resp_res     <= alu_res;
                        result       <= alu_res;
                        result_valid <= 1'b1;
                    end
                end
                S_RESP: if (tx_start) tx_idx <= tx_idx + 4'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_frame_engine.sv
// Directed bench for uart_cmd_frame_engine (OPERAND_W=16, TIMEOUT_CYCLES=100).
// Expected TX bytes are queued when a frame is driven and checked as they leave.
module tb_uart_cmd_frame_engine;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         tx_busy;
    logic         tx_start;
    logic [7:0]   tx_data;
    logic [W-1:0] result;
    logic         result_valid, timeout, rx_overrun;

    int checks = 0;
    int errors = 0;
    int rv_cnt = 0, tmo_seen = 0, ovr_cnt = 0, tx_cnt = 0, busy_cnt = 0;
    int rv0, tmo0, tx0, ovr0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    uart_cmd_frame_engine #(.OPERAND_W(W), .TIMEOUT_CYCLES(100)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_busy      (tx_busy),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .result       (result),
        .result_valid (result_valid),
        .timeout      (timeout),
        .rx_overrun   (rx_overrun)
    );

    always #5 clk = ~clk;

    // UART_TX model: busy rises one cycle after start and holds for 10 cycles
    always @(posedge clk) begin
        if (tx_start)          busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt > 0);

    // Output monitor and scoreboard
    always @(negedge clk) begin
        if (result_valid) rv_cnt++;
        if (timeout)      tmo_seen++;
        if (rx_overrun)   ovr_cnt++;
        if (tx_start) begin
            tx_cnt++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL tx_unexpected got=%02h exp=none", tx_data);
            end
            if (exp_q.size() != 0) begin
                exp_b = exp_q.pop_front();
                assert (tx_data === exp_b) else begin
                    errors++;
                    $error("FAIL tx_byte got=%02h exp=%02h", tx_data, exp_b);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                              input logic [7:0] ck);
        send_byte(8'hA5);
        send_byte(op);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        send_byte(b[15:8]);
        send_byte(b[7:0]);
        send_byte(ck);
    endtask

    task automatic push_resp(input logic [7:0] st, input logic [15:0] r);
        exp_q.push_back(8'h5A);
        exp_q.push_back(st);
        exp_q.push_back(r[15:8]);
        exp_q.push_back(r[7:0]);
        exp_q.push_back(st ^ r[15:8] ^ r[7:0]);
    endtask

    task automatic wait_left(input int n, input string tag);
        for (int i = 0; i < 400 && exp_q.size() > n; i++) @(negedge clk);
        chk(tag, (exp_q.size() > n) ? 32'd1 : 32'd0, 32'd0);
    endtask

    task automatic wait_resp(input string tag);
        wait_left(0, tag);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {4'd0, tx_start, tx_data, result, result_valid, timeout, rx_overrun}, 32'd0);
        reset = 1'b1;

        // Noise in IDLE, then ADD with N+2 timing checks
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        push_resp(8'h00, 16'h1235);
        rv0 = rv_cnt;
        send_frame(8'h00, 16'h1234, 16'h0001, 8'h27);
        @(negedge clk);
        chk("add_rv_at_n2", result_valid, 1);
        chk("add_tx_at_n2", tx_start, 1);
        @(negedge clk);
        chk("add_rv_single", result_valid, 0);
        wait_resp("add_resp_done");
        chk("add_result", result, 16'h1235);
        chk("add_rv_count", rv_cnt - rv0, 1);

        // SUB with borrow
        push_resp(8'h80, 16'hFFFF);
        send_frame(8'h01, 16'h0001, 16'h0002, 8'h02);
        wait_resp("sub_resp_done");
        chk("sub_result", result, 16'hFFFF);

        // Bad checksum
        push_resp(8'h02, 16'h0000);
        rv0 = rv_cnt;
        send_frame(8'h00, 16'h0001, 16'h0001, 8'hFF);
        wait_resp("chk_resp_done");
        chk("chk_result_kept", result, 16'hFFFF);
        chk("chk_no_rv", rv_cnt - rv0, 0);

        // Bad opcode
        push_resp(8'h01, 16'h0000);
        rv0 = rv_cnt;
        send_frame(8'h0F, 16'h0000, 16'h0000, 8'h0F);
        wait_resp("badop_resp_done");
        chk("badop_result_kept", result, 16'hFFFF);
        chk("badop_no_rv", rv_cnt - rv0, 0);

        // MUL (optional)
`ifdef UART_CMD_MUL_EN
        push_resp(8'h80, 16'h0000);
        send_frame(8'h08, 16'h0100, 16'h0100, 8'h08);
        wait_resp("mul_resp_done");
        chk("mul_result", result, 16'h0000);
`else
        push_resp(8'h01, 16'h0000);
        send_frame(8'h08, 16'h0100, 16'h0100, 8'h08);
        wait_resp("mul_resp_done");
        chk("mul_result_kept", result, 16'hFFFF);
`endif

        // Inter-byte timeout
        tmo0 = tmo_seen;
        tx0  = tx_cnt;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h12);
        repeat (95) @(negedge clk);
        chk("tmo_not_early", tmo_seen - tmo0, 0);
        repeat (15) @(negedge clk);
        chk("tmo_one_pulse", tmo_seen - tmo0, 1);
        chk("tmo_no_tx", tx_cnt - tx0, 0);
        push_resp(8'h00, 16'h1235);
        send_frame(8'h00, 16'h1234, 16'h0001, 8'h27);
        wait_resp("tmo_next_resp_done");
        chk("tmo_next_result", result, 16'h1235);

        // Byte injected during RESP
        ovr0 = ovr_cnt;
        push_resp(8'h00, 16'h0005);
        send_frame(8'h00, 16'h0002, 16'h0003, 8'h01);
        wait_left(3, "ovr_wait_tx");
        send_byte(8'hA5);
        @(negedge clk);
        chk("ovr_pulse", ovr_cnt - ovr0, 1);
        wait_resp("ovr_resp_done");
        chk("ovr_result", result, 16'h0005);

        // Reset in the middle of a response
        push_resp(8'h00, 16'h0007);
        send_frame(8'h00, 16'h0003, 16'h0004, 8'h07);
        wait_left(3, "rst_wait_tx");
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_tx_start", tx_start, 0);
        chk("rst_result", result, 16'h0000);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        push_resp(8'h00, 16'h1235);
        send_frame(8'h00, 16'h1234, 16'h0001, 8'h27);
        wait_resp("post_rst_resp_done");
        chk("post_rst_result", result, 16'h1235);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
